fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the byte address fetched first after reset.
REQ-002 SHALL have parameter NOP_INSTR, default 32'h0000_0013 (ADDI x0,x0,0), the value driven on out_instr while out_valid=0.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 Port list, in this order:
- clk  input  1  clock, all state updates on the rising edge.
- rst  input  1  synchronous active-high reset.
- rom_addr  output  32  word index into the program ROM.
- rom_data  input  32  instruction word returned combinationally by the ROM for rom_addr.
- out_valid  output  1  an instruction is presented to decode.
- out_ready  input  1  decode accepts the presented instruction.
- out_instr  output  32  instruction presented to decode.
- out_pc  output  32  byte address of out_instr.
- redirect_valid  input  1  branch or jump redirect request.
- redirect_pc  input  32  byte target of the redirect.
- fault  output  1  misaligned redirect target held.
- fault_pc  output  32  offending target address.

Function
REQ-005 SHALL hold a 32-bit byte PC; rom_addr SHALL equal {2'b00, pc[31:2]} combinationally.
REQ-006 SHALL buffer fetched instructions in a 2-entry FIFO of {pc, instr} pairs; out_valid = (count != 0); out_instr and out_pc SHALL come from the head entry.
REQ-007 Dequeue SHALL occur on a cycle with out_valid=1 and out_ready=1.
REQ-008 In state RUN without a redirect, a fetch SHALL occur when count<2 or a dequeue happens in the same cycle. A fetch writes {pc, rom_data} at the tail and sets pc <= pc+4.
REQ-009 PC arithmetic SHALL be modulo 2^32: 32'hFFFF_FFFC + 4 SHALL give 32'h0000_0000.
REQ-010 Simultaneous fetch and dequeue with count=2 SHALL leave count=2 and preserve order; with count=1 the new entry SHALL become head on the next cycle.
REQ-011 Fetch-to-valid latency SHALL be 1 cycle; when the FIFO is empty and out_ready=1, one instruction SHALL be accepted per cycle.
REQ-012 redirect_valid=1 SHALL have priority over all other activity:
- the FIFO is flushed (count <= 0);
- no fetch and no dequeue occur that cycle;
- pc <= redirect_pc;
- out_valid is 0 on the following cycle.
REQ-013 FSM states SHALL be RUN and FAULT. RUN->FAULT SHALL occur on a redirect with redirect_pc[1:0] != 2'b00; this sets fault=1 and fault_pc=redirect_pc.
REQ-014 In FAULT no fetch SHALL occur and out_valid SHALL be 0.
REQ-015 FAULT->RUN SHALL occur only on a redirect with an aligned redirect_pc; this clears fault.
REQ-016 A misaligned redirect received while already in FAULT SHALL update fault_pc.
REQ-017 out_instr SHALL equal NOP_INSTR and out_pc SHALL hold its last value whenever out_valid=0.
REQ-018 When out_valid=1 and out_ready=0, out_instr and out_pc SHALL stay stable until dequeued or flushed.

Reset
REQ-019 On rst=1 at a clock edge, the block SHALL set:
- pc=RESET_PC, count=0, state=RUN;
- fault=0, fault_pc=0, out_pc=0;
- out_valid=0, out_instr=NOP_INSTR.
REQ-020 rst SHALL override a simultaneous redirect_valid and discard all buffered entries.
REQ-021 On the first cycle after rst deasserts, rom_addr SHALL be RESET_PC>>2, and out_valid SHALL rise one cycle later.

Verification
REQ-022 Reset release, out_ready=1, ROM word0=32'h0010_0093 -> cycle 1: out_valid=1, out_instr=32'h0010_0093, out_pc=0; cycle 2: out_pc=4.
REQ-023 out_ready=0 for 5 cycles after reset -> count saturates at 2 and pc stalls at 8. Raising out_ready then yields out_pc 0, 4, 8, 12 on consecutive cycles with no gaps or duplicates.
REQ-024 redirect_valid=1, redirect_pc=32'h40 while count=2 -> next cycle out_valid=0 and rom_addr=16; the cycle after, out_pc=32'h40.
REQ-025 redirect_pc=32'h42 -> fault=1, fault_pc=32'h42, out_valid stays 0 for 10 cycles. Then redirect_pc=32'h80 -> fault=0 and out_pc=32'h80 two cycles later.
REQ-026 Redirect to 32'hFFFF_FFFC with out_ready=1 -> out_pc sequence FFFF_FFFC, 0000_0000.
REQ-027 rst=1 asserted mid-stream with count=2 and redirect_valid=1 -> next cycle out_valid=0, fault=0, rom_addr=RESET_PC>>2.

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch front end.
// Holds a byte PC, reads one word per cycle from a combinational ROM and
// buffers {pc, instr} pairs in a 2-entry FIFO presented to decode with a
// valid/ready handshake. Redirects flush the buffer and reload the PC; a
// misaligned redirect target parks the stage in FAULT until an aligned
// redirect arrives.
//
// Ports:
//   clk            clock, rising edge
//   rst            synchronous active-high reset
//   rom_addr       word index into program ROM ({2'b00, pc[31:2]})
//   rom_data       ROM word for rom_addr (combinational)
//   out_valid      head entry presented to decode
//   out_ready      decode accepts the head entry
//   out_instr      head instruction, NOP_INSTR when not valid
//   out_pc         head byte address, holds last value when not valid
//   redirect_valid branch/jump redirect request (highest priority)
//   redirect_pc    redirect byte target
//   fault          misaligned redirect target held
//   fault_pc       offending target address

package fetch_stage_pkg;
    localparam int unsigned XLEN = 32;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;
endpackage

module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic             clk,
    input  logic             rst,
    output logic [XLEN-1:0]  rom_addr,
    input  logic [XLEN-1:0]  rom_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_instr,
    output logic [XLEN-1:0]  out_pc,
    input  logic             redirect_valid,
    input  logic [XLEN-1:0]  redirect_pc,
    output logic             fault,
    output logic [XLEN-1:0]  fault_pc
);

    localparam int unsigned CNT_W = 2;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FAULT = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [XLEN-1:0]     pc_q, pc_d;
    logic [CNT_W-1:0]    count_q, count_d;
    fetch_entry_t        head_q, head_d;
    fetch_entry_t        tail_q, tail_d;
    logic                fault_q, fault_d;
    logic [XLEN-1:0]     fault_pc_q, fault_pc_d;
    logic [XLEN-1:0]     hold_pc_q, hold_pc_d;

    logic                deq;
    logic                fetch;
    fetch_entry_t        new_entry;

    // Outputs are thin views of the registered FIFO head and PC.
    assign rom_addr  = {2'b00, pc_q[XLEN-1:2]};
    assign out_valid = (count_q != CNT_W'(0));
    assign out_instr = out_valid ? head_q.instr : NOP_INSTR;
    assign out_pc    = out_valid ? head_q.pc : hold_pc_q;
    assign fault     = fault_q;
    assign fault_pc  = fault_pc_q;

    // Remember the last presented pc so out_pc holds across empty cycles.
    assign hold_pc_d = out_pc;

    // Next-state: redirect first, then fetch/dequeue bookkeeping in RUN.
    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        count_d         = count_q;
        head_d          = head_q;
        tail_d          = tail_q;
        fault_d         = fault_q;
        fault_pc_d      = fault_pc_q;
        deq             = 1'b0;
        fetch           = 1'b0;
        new_entry.pc    = pc_q;
        new_entry.instr = rom_data;

        if (redirect_valid) begin
            pc_d    = redirect_pc;
            count_d = CNT_W'(0);
            if (redirect_pc[1:0] != 2'b00) begin
                state_d    = ST_FAULT;
                fault_d    = 1'b1;
                fault_pc_d = redirect_pc;
            end else begin
                state_d = ST_RUN;
                fault_d = 1'b0;
            end
        end else begin
            case (state_q)
                ST_RUN: begin
                    deq   = out_valid && out_ready;
                    fetch = (count_q < CNT_W'(2)) || deq;
                end
                ST_FAULT: begin
                    deq   = 1'b0;
                    fetch = 1'b0;
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end

        if (fetch) begin
            pc_d = pc_q + XLEN'(4);
        end

        // Head is always entry 0; with a full buffer the tail shifts up.
        case ({fetch, deq})
            2'b10: begin
                if (count_q == CNT_W'(0)) begin
                    head_d = new_entry;
                end else begin
                    tail_d = new_entry;
                end
                count_d = count_q + CNT_W'(1);
            end
            2'b01: begin
                head_d  = tail_q;
                count_d = count_q - CNT_W'(1);
            end
            2'b11: begin
                if (count_q == CNT_W'(2)) begin
                    head_d = tail_q;
                    tail_d = new_entry;
                end else begin
                    head_d = new_entry;
                end
            end
            default: begin
            end
        endcase
    end

    // State register with synchronous reset overriding any redirect.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_RUN;
            pc_q       <= RESET_PC;
            count_q    <= CNT_W'(0);
            head_q     <= '0;
            tail_q     <= '0;
            fault_q    <= 1'b0;
            fault_pc_q <= '0;
            hold_pc_q  <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            count_q    <= count_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            fault_q    <= fault_d;
            fault_pc_q <= fault_pc_d;
            hold_pc_q  <= hold_pc_d;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scenarios plus randomized traffic against a
// queue-based reference model of the fetch stream.
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic [31:0] rom_addr;
    logic [31:0] rom_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fault;
    logic [31:0] fault_pc;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] m_pc;
    bit          m_fault;
    logic [31:0] m_fault_pc;
    logic [31:0] m_hold_pc;
    bit          model_ok = 1'b0;
    int          checks   = 0;
    int          failures = 0;

    // Program ROM contents, indexed by word.
    function automatic logic [31:0] rom_word(input logic [31:0] widx);
        if (widx == 32'd0) return 32'h0010_0093;
        return (widx * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
    endfunction

    assign rom_data = rom_word(rom_addr);

    fetch_stage #(
        .RESET_PC (RESET_PC),
        .NOP_INSTR(NOP_INSTR)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rom_addr      (rom_addr),
        .rom_data      (rom_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_instr     (out_instr),
        .out_pc        (out_pc),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .fault         (fault),
        .fault_pc      (fault_pc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h time=%0t", name, act, exp_v, $time);
        end
    endtask

    // Reference model advanced at each clock edge using the inputs applied there.
    // The fetch stream keeps the two-deep buffer topped up while not faulted;
    // reset and redirects restart the stream at a new address.
    task automatic model_edge();
        exp_t e;
        if (rst) begin
            exp_q.delete();
            m_pc       = RESET_PC;
            m_fault    = 1'b0;
            m_fault_pc = 32'h0;
            m_hold_pc  = 32'h0;
            model_ok   = 1'b1;
        end else if (!model_ok) begin
            m_pc = RESET_PC;
        end else if (redirect_valid) begin
            exp_q.delete();
            m_pc = redirect_pc;
            if (redirect_pc[1:0] != 2'b00) begin
                m_fault    = 1'b1;
                m_fault_pc = redirect_pc;
            end else begin
                m_fault = 1'b0;
            end
        end else if (!m_fault && exp_q.size() < 2) begin
            e.pc    = m_pc;
            e.instr = rom_word({2'b00, m_pc[31:2]});
            exp_q.push_back(e);
            m_pc = m_pc + 32'd4;
        end
    endtask

    task automatic drive(input bit r, input bit rv, input logic [31:0] rp, input bit rdy);
        @(posedge clk);
        model_edge();
        #1;
        rst            = r;
        redirect_valid = rv;
        redirect_pc    = rp;
        out_ready      = rdy;
    endtask

    // Monitor: compare DUT outputs with the model mid-cycle, pop on acceptance.
    always @(negedge clk) begin
        if (model_ok) begin
            chk("rom_addr", rom_addr, {2'b00, m_pc[31:2]});
            chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
            chk("fault", 32'(fault), 32'(m_fault));
            chk("fault_pc", fault_pc, m_fault_pc);
            if (out_valid) begin
                if (exp_q.size() != 0) begin
                    chk("out_pc", out_pc, exp_q[0].pc);
                    chk("out_instr", out_instr, exp_q[0].instr);
                    m_hold_pc = exp_q[0].pc;
                    if (out_ready && !rst && !redirect_valid) begin
                        void'(exp_q.pop_front());
                    end
                end
            end else begin
                chk("idle_instr", out_instr, NOP_INSTR);
                chk("idle_pc", out_pc, m_hold_pc);
            end
        end
    end

    initial begin
        bit          r;
        bit          rv;
        bit          rdy;
        logic [31:0] rp;

        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        out_ready      = 1'b1;

        // Reset release with decode always ready.
        drive(1'b1, 1'b0, 32'h0, 1'b1);
        drive(0, 0, 32'h0, 1'b1);
        repeat (6) drive(0, 0, 32'h0, 1'b1);

        // Decode stalled after reset, then drained.
        drive(1'b1, 0, 32'h0, 1'b0);
        repeat (6) drive(0, 0, 32'h0, 1'b0);
        repeat (6) drive(0, 0, 32'h0, 1'b1);

        // Redirect while the buffer is full.
        repeat (3) drive(0, 0, 32'h0, 1'b0);
        drive(0, 1'b1, 32'h40, 1'b0);
        repeat (5) drive(0, 0, 32'h0, 1'b1);

        // Misaligned redirect, idle in fault, then recover.
        drive(0, 1'b1, 32'h42, 1'b1);
        repeat (10) drive(0, 0, 32'h0, 1'b1);
        drive(0, 1'b1, 32'h80, 1'b1);
        repeat (4) drive(0, 0, 32'h0, 1'b1);

        // Second misaligned target while already faulted.
        drive(0, 1'b1, 32'h42, 1'b1);
        drive(0, 0, 32'h0, 1'b1);
        drive(0, 1'b1, 32'h101, 1'b1);
        repeat (2) drive(0, 0, 32'h0, 1'b1);
        drive(0, 1'b1, 32'h1000, 1'b0);
        repeat (3) drive(0, 0, 32'h0, 1'b1);

        // PC wrap at the top of the address space.
        drive(0, 1'b1, 32'hFFFF_FFFC, 1'b1);
        repeat (5) drive(0, 0, 32'h0, 1'b1);

        // Reset colliding with a redirect while the buffer is full.
        repeat (3) drive(0, 0, 32'h0, 1'b0);
        drive(1'b1, 1'b1, 32'h200, 1'b0);
        drive(0, 0, 32'h0, 1'b1);
        repeat (4) drive(0, 0, 32'h0, 1'b1);

        // Randomized traffic.
        repeat (3000) begin
            r   = ($urandom_range(0, 199) == 0);
            rv  = ($urandom_range(0, 99) < 6);
            rp  = $urandom;
            if ($urandom_range(0, 2) != 0) rp[1:0] = 2'b00;
            rdy = ($urandom_range(0, 99) < 70);
            drive(r, rv, rp, rdy);
        end
        drive(0, 0, 32'h0, 1'b1);

        @(posedge clk);
        model_edge();
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
